// File: rtl/pp_shift_accumulator.sv
// pp_shift_accumulator: sequential shift-and-add multiplier driving an external AND stage.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module pp_shift_accumulator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [WIDTH-1:0]   pp_a,
  output logic               pp_bit,
  input  logic [WIDTH-1:0]   pp_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state, w_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept, w_last;
  assign w_accept = start && (r_state != RUN);
`ifdef EARLY_TERM_EN
  assign w_last = (r_b >> 1) == '0;
`else
  assign w_last = r_cnt == CNT_W'(WIDTH - 1);
`endif
  always_comb begin
    w_next = r_state;
    w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (w_accept ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_a   <= a_in;
      r_b   <= b_in;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_acc <= r_acc + ({{WIDTH{1'b0}}, pp_in} << r_cnt);
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  assign busy    = r_state == RUN;
  assign done    = r_state == DONE;
  assign product = r_acc;
  // Gate the AND-stage operands so its output is zero whenever we are not running
  assign pp_a    = busy ? r_a : '0;
  assign pp_bit  = busy & r_b[0];
endmodule

// File: tb/tb_pp_shift_accumulator.sv
// tb_pp_shift_accumulator: directed tests against an arithmetic reference model of the multiplier.
module tb_pp_shift_accumulator;
  localparam int W = 4;
`ifdef EARLY_TERM_EN
  localparam bit ET = 1;
`else
  localparam bit ET = 0;
`endif
  logic         clk = 0, rst = 1, start = 0;
  logic [W-1:0] a_in = 0, b_in = 0;
  logic [W-1:0] pp_a, pp_in;
  logic         pp_bit, busy, done;
  logic [2*W-1:0] product;
  int checks = 0, errors = 0, cyc = 0, nb = 0;
  logic [7:0] seq;

  pp_shift_accumulator #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .pp_a(pp_a), .pp_bit(pp_bit), .pp_in(pp_in), .busy(busy), .done(done), .product(product)
  );

  assign pp_in = pp_a & {W{pp_bit}};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a run consumes one multiplier bit per cycle for run_len cycles
  int m_run = 0, m_steps = 0;
  logic m_done = 0;
  logic [W-1:0] m_a = 0, m_b = 0;

  function automatic int run_len(input logic [W-1:0] b);
    int h = 0;
    if (!ET) return W;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    return h + 1;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_run = 0; m_steps = 0; m_done = 0; m_a = 0; m_b = 0;
    end else if (m_run > 0) begin
      m_steps++;
      m_run--;
      m_done = (m_run == 0);
    end else begin
      m_done = 0;
      if (start) begin
        m_a = a_in; m_b = b_in; m_steps = 0; m_run = run_len(b_in);
      end
    end

  always @(negedge clk)
    if (!rst) begin
      int eb, ep;
      eb = (m_run > 0) ? int'(m_b[m_steps]) : 0;
      ep = int'(m_a) * (int'(m_b) % (1 << m_steps));
      chk("busy", int'(busy), int'(m_run > 0));
      chk("done", int'(done), int'(m_done));
      chk("product", int'(product), ep);
      chk("pp_a", int'(pp_a), (m_run > 0) ? int'(m_a) : 0);
      chk("pp_bit", int'(pp_bit), eb);
    end

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) begin seq[nb] = pp_bit; nb++; end
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, output int t0, output int dc);
    @(posedge clk); #2 a_in = a; b_in = b; start = 1;
    @(posedge clk); #2 start = 0; t0 = cyc;
    nb = 0; seq = 0;
    wait_done(dc);
  endtask

  initial begin
    int t0, dc, d1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_pp_a", int'(pp_a), 0);
    chk("rst_pp_bit", int'(pp_bit), 0);
    @(posedge clk); #2 rst = 0;

    op(15, 15, t0, dc);
    chk("15x15_lat", dc - t0 + 1, 5);
    chk("15x15_busy_cycles", nb, 4);
    chk("15x15_prod", int'(product), 225);
    repeat (3) @(negedge clk);
    chk("15x15_hold", int'(product), 225);

    op(7, 5, t0, dc);
    chk("7x5_ppbits", int'(seq[3:0]), 4'b0101);
    chk("7x5_prod", int'(product), 35);
    chk("7x5_lat", dc - t0 + 1, ET ? 4 : 5);

    op(9, 0, t0, dc);
    chk("9x0_prod", int'(product), 0);
    chk("9x0_lat", dc - t0 + 1, ET ? 2 : 5);
    op(9, 1, t0, dc);
    chk("9x1_prod", int'(product), 9);
    chk("9x1_lat", dc - t0 + 1, ET ? 2 : 5);
    op(9, 8, t0, dc);
    chk("9x8_prod", int'(product), 72);
    chk("9x8_lat", dc - t0 + 1, 5);

    @(posedge clk); #2 a_in = 3; b_in = 4; start = 1;
    @(posedge clk); #2 start = 0; t0 = cyc;
    @(posedge clk); #2 a_in = 15; b_in = 15; start = 1;
    @(posedge clk); #2 start = 0;
    wait_done(dc);
    chk("ignored_prod", int'(product), 12);
    chk("ignored_lat", dc - t0 + 1, ET ? 4 : 5);

    @(posedge clk); #2 a_in = 3; b_in = 4; start = 1;
    @(posedge clk); #2 t0 = cyc;
    wait_done(d1);
    chk("b2b_prod1", int'(product), 12);
    a_in = 6; b_in = 6;
    @(posedge clk); #2 start = 0;
    chk("b2b_no_bubble", int'(busy), 1);
    chk("b2b_restart_prod", int'(product), 0);
    wait_done(dc);
    chk("b2b_prod2", int'(product), 36);
    chk("b2b_spacing", dc - d1, ET ? 4 : 5);

    @(posedge clk); #2 a_in = 15; b_in = 15; start = 1;
    @(posedge clk); #2 start = 0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_product", int'(product), 0);
    chk("arst_pp_a", int'(pp_a), 0);
    chk("arst_pp_bit", int'(pp_bit), 0);
    chk("arst_done", int'(done), 0);
    #1 rst = 0;
    op(2, 3, t0, dc);
    chk("2x3_prod", int'(product), 6);
    chk("2x3_lat", dc - t0 + 1, ET ? 3 : 5);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
